rgb_pixel_packer: RTL

Downstream stage of the YUV422->RGB APB converter. It captures each converted group of 4 RGB888 pixels when the converter's completion pulse fires, and buffers the groups in a small FIFO. Each group is emitted as three packed 32-bit words (12 bytes, no padding) on a valid/ready stream toward the DMA/display write path. Overflow is flagged rather than back-pressuring the converter, which has no stall input.

---
 rtl/rgb_pixel_packer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/rgb_pixel_packer.sv
// Buffers 4-pixel RGB888 groups captured on cap_strobe and streams each as three packed 32-bit words.
// Word0 is valid one edge after pop. Words hold while m_ready=0. A full FIFO drops captures and sets sticky overflow.

module pixel_fifo #(
    parameter  int W     = 96,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdat,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [LW-1:0] level
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr;
    logic          rd;

    // Fullness is judged on the pre-edge level, so a same-edge pop never frees room for a push.
    assign wr   = push && (level != LW'(DEPTH));
    assign rd   = pop && (level != '0);
    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= wdat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr && !rd) begin
                level <= level + LW'(1);
            end else if (!wr && rd) begin
                level <= level - LW'(1);
            end
        end
    end
endmodule

module rgb_pixel_packer #(
    parameter  int FIFO_DEPTH = 4,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cap_strobe,
    input  logic [3:0][2:0][7:0]  rgb_in,
    output logic [31:0]           m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  busy,
    output logic                  overflow,
    input  logic                  ovf_clr
);
    typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [95:0] pix;
    logic [95:0] head;
    logic [95:0] hold;
    logic [95:0] hold_nxt;
    logic [31:0] data_nxt;
    logic        valid_nxt;
    logic        last_nxt;
    logic        pop;
    logic        fire;
    logic        empty;
    logic        full;

    // Byte order on the wire is R0 G0 B0 R1 G1 ... B3, first byte in the MSBs.
    assign pix = {rgb_in[0][0], rgb_in[0][1], rgb_in[0][2],
                  rgb_in[1][0], rgb_in[1][1], rgb_in[1][2],
                  rgb_in[2][0], rgb_in[2][1], rgb_in[2][2],
                  rgb_in[3][0], rgb_in[3][1], rgb_in[3][2]};

    pixel_fifo #(
        .W     (96),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (pclk),
        .rst   (preset),
        .push  (cap_strobe),
        .wdat  (pix),
        .pop   (pop),
        .head  (head),
        .level (fifo_level)
    );

    assign empty = (fifo_level == '0);
    assign full  = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign fire  = m_valid && m_ready;
    assign busy  = (state != IDLE) || !empty;

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        data_nxt  = m_data;
        valid_nxt = m_valid;
        last_nxt  = m_last;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    hold_nxt  = head;
                    data_nxt  = head[95:64];
                    valid_nxt = 1'b1;
                    state_nxt = W0;
                end
            end
            W0: begin
                if (fire) begin
                    data_nxt  = hold[63:32];
                    state_nxt = W1;
                end
            end
            W1: begin
                if (fire) begin
                    data_nxt  = hold[31:0];
                    last_nxt  = 1'b1;
                    state_nxt = W2;
                end
            end
            W2: begin
                if (fire) begin
                    last_nxt = 1'b0;
                    // Chain straight into the next queued group to avoid a bubble.
                    if (!empty) begin
                        pop       = 1'b1;
                        hold_nxt  = head;
                        data_nxt  = head[95:64];
                        state_nxt = W0;
                    end else begin
                        valid_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state   <= IDLE;
            hold    <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            state   <= state_nxt;
            hold    <= hold_nxt;
            m_data  <= data_nxt;
            m_valid <= valid_nxt;
            m_last  <= last_nxt;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            overflow <= 1'b0;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end else if (cap_strobe && full) begin
            overflow <= 1'b1;
        end
    end
endmodule
